// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - shared types and default timing for the intersection blocks
package intersection_pkg;

    typedef enum logic {
        IDLE,
        WAITING
    } ped_req_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_TURN_HOLD       = 8;
    localparam int DEFAULT_MAX_WAIT        = 100;

endpackage

// File: rtl/request_conditioner_debounce.sv
// rtl/request_conditioner_debounce.sv - two-flop synchroniser plus stable-level debounce counter
module debounce #(
    parameter int CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int             CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the sample disagrees with the stable level,
    // so any agreeing sample restarts the qualification window.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/request_conditioner.sv
// rtl/request_conditioner.sv - debounces, latches and qualifies pedestrian and turn requests
module request_conditioner
    import intersection_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TURN_HOLD       = DEFAULT_TURN_HOLD,
    parameter int MAX_WAIT        = DEFAULT_MAX_WAIT
) (
    input  logic clock,
    input  logic reset,
    input  logic pedestrian_button_raw,
    input  logic turn_sensor_raw,
    input  logic pedestrian_green,
    input  logic turn_green,
    output logic pedestrian_button,
    output logic turn_sensor,
    output logic ped_overdue,
    output logic turn_served
);

    localparam int                HOLD_W   = $clog2(TURN_HOLD + 1);
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TURN_HOLD);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic ped_level;
    logic turn_level;

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ped_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (pedestrian_button_raw),
        .level (ped_level)
    );

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_turn_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (turn_sensor_raw),
        .level (turn_level)
    );

    ped_req_state_t    state_q, state_d;
    logic              ped_level_prev_q, ped_level_prev_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [HOLD_W-1:0] presence_cnt_q, presence_cnt_d;
    logic              turn_green_prev_q, turn_green_prev_d;
    logic              turn_served_q, turn_served_d;
    logic              ped_rise;

    // Service feedback takes priority so a press coinciding with the green is dropped.
    always_comb begin
        ped_level_prev_d = ped_level;
        ped_rise         = ped_level & ~ped_level_prev_q;
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        if (pedestrian_green) begin
            state_d    = IDLE;
            wait_cnt_d = '0;
        end else if (state_q == IDLE) begin
            wait_cnt_d = '0;
            if (ped_rise) begin
                state_d = WAITING;
            end
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        presence_cnt_d = '0;
        if (turn_level) begin
            presence_cnt_d = (presence_cnt_q == HOLD_MAX) ? presence_cnt_q
                                                          : presence_cnt_q + 1'b1;
        end
        turn_green_prev_d = turn_green;
        turn_served_d     = turn_green_prev_q & ~turn_green;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            ped_level_prev_q  <= 1'b0;
            wait_cnt_q        <= '0;
            presence_cnt_q    <= '0;
            turn_green_prev_q <= 1'b0;
            turn_served_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            ped_level_prev_q  <= ped_level_prev_d;
            wait_cnt_q        <= wait_cnt_d;
            presence_cnt_q    <= presence_cnt_d;
            turn_green_prev_q <= turn_green_prev_d;
            turn_served_q     <= turn_served_d;
        end
    end

    assign pedestrian_button = (state_q == WAITING);
    assign ped_overdue       = (wait_cnt_q == WAIT_MAX);
    assign turn_sensor       = (presence_cnt_q == HOLD_MAX);
    assign turn_served       = turn_served_q;

endmodule

// File: tb/tb_request_conditioner.sv
// tb/tb_request_conditioner.sv - directed self-checking bench for request_conditioner
module tb_request_conditioner;

    logic clock = 1'b0;
    logic reset;
    logic pedestrian_button_raw;
    logic turn_sensor_raw;
    logic pedestrian_green;
    logic turn_green;
    logic pedestrian_button;
    logic turn_sensor;
    logic ped_overdue;
    logic turn_served;

    int tests    = 0;
    int failures = 0;

    request_conditioner dut (
        .clock                 (clock),
        .reset                 (reset),
        .pedestrian_button_raw (pedestrian_button_raw),
        .turn_sensor_raw       (turn_sensor_raw),
        .pedestrian_green      (pedestrian_green),
        .turn_green            (turn_green),
        .pedestrian_button     (pedestrian_button),
        .turn_sensor           (turn_sensor),
        .ped_overdue           (ped_overdue),
        .turn_served           (turn_served)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Leaves the bench at cycle 0: one step after the reset edge, inputs idle.
    task automatic do_reset();
        reset                 = 1'b1;
        pedestrian_button_raw = 1'b0;
        turn_sensor_raw       = 1'b0;
        pedestrian_green      = 1'b0;
        turn_green            = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset                 = 1'b1;
        pedestrian_button_raw = 1'b1;
        turn_sensor_raw       = 1'b1;
        pedestrian_green      = 1'b0;
        turn_green            = 1'b1;
        tick(3);
        tests++;
        if (pedestrian_button !== 1'b0) begin
            failures++;
            $display("FAIL reset_pedestrian_button: got %b expected 0", pedestrian_button);
        end
        tests++;
        if (turn_sensor !== 1'b0) begin
            failures++;
            $display("FAIL reset_turn_sensor: got %b expected 0", turn_sensor);
        end
        tests++;
        if (ped_overdue !== 1'b0) begin
            failures++;
            $display("FAIL reset_ped_overdue: got %b expected 0", ped_overdue);
        end
        tests++;
        if (turn_served !== 1'b0) begin
            failures++;
            $display("FAIL reset_turn_served: got %b expected 0", turn_served);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tests++;
            if (pedestrian_button !== 1'b0 || ped_overdue !== 1'b0) begin
                failures++;
                $display("FAIL bounce cycle %0d: got button=%b overdue=%b expected 0 0",
                         c, pedestrian_button, ped_overdue);
            end
            pedestrian_button_raw = (c < 20) && ((c / 3) % 2 == 0);
            tick(1);
        end
    endtask

    task automatic test_clean_press();
        logic exp;
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            exp = (c >= 17) && (c <= 30);
            tests++;
            if (pedestrian_button !== exp) begin
                failures++;
                $display("FAIL clean_press cycle %0d: got %b expected %b", c, pedestrian_button, exp);
            end
            pedestrian_button_raw = (c >= 10);
            pedestrian_green      = (c == 30);
            tick(1);
        end
        pedestrian_button_raw = 1'b0;
    endtask

    task automatic test_overdue();
        logic exp_btn;
        logic exp_od;
        do_reset();
        for (int c = 0; c <= 160; c++) begin
            exp_btn = (c >= 7) && (c <= 150);
            exp_od  = (c >= 107) && (c <= 150);
            tests++;
            if (pedestrian_button !== exp_btn || ped_overdue !== exp_od) begin
                failures++;
                $display("FAIL overdue cycle %0d: got button=%b overdue=%b expected %b %b",
                         c, pedestrian_button, ped_overdue, exp_btn, exp_od);
            end
            pedestrian_button_raw = 1'b1;
            pedestrian_green      = (c == 150);
            tick(1);
        end
        pedestrian_button_raw = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            tests++;
            if (pedestrian_button !== 1'b0) begin
                failures++;
                $display("FAIL simultaneous_pulse cycle %0d: got %b expected 0", c, pedestrian_button);
            end
            pedestrian_button_raw = 1'b1;
            pedestrian_green      = (c == 6);
            tick(1);
        end
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            tests++;
            if (pedestrian_button !== 1'b0) begin
                failures++;
                $display("FAIL simultaneous_window cycle %0d: got %b expected 0", c, pedestrian_button);
            end
            pedestrian_button_raw = 1'b1;
            pedestrian_green      = (c >= 4) && (c <= 9);
            tick(1);
        end
        pedestrian_button_raw = 1'b0;
        pedestrian_green      = 1'b0;
    endtask

    task automatic test_turn();
        logic exp;
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            exp = (c >= 14) && (c <= 46);
            tests++;
            if (turn_sensor !== exp) begin
                failures++;
                $display("FAIL turn cycle %0d: got %b expected %b", c, turn_sensor, exp);
            end
            turn_sensor_raw = (c < 40) && !((c >= 20) && (c <= 22));
            turn_green      = (c >= 30) && (c <= 32);
            tick(1);
        end
        turn_sensor_raw = 1'b0;
        turn_green      = 1'b0;
    endtask

    task automatic test_turn_served();
        logic exp;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            exp = (c == 6);
            tests++;
            if (turn_served !== exp) begin
                failures++;
                $display("FAIL turn_served cycle %0d: got %b expected %b", c, turn_served, exp);
            end
            turn_green = (c <= 4);
            tick(1);
        end
        turn_green = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        logic exp_btn;
        logic exp_turn;
        do_reset();
        for (int c = 0; c <= 90; c++) begin
            exp_btn  = ((c >= 7) && (c <= 57)) || (c >= 87);
            exp_turn = (c >= 14) && (c <= 57);
            tests++;
            if (pedestrian_button !== exp_btn || turn_sensor !== exp_turn ||
                ped_overdue !== 1'b0 || turn_served !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_request cycle %0d: got button=%b turn=%b overdue=%b served=%b expected %b %b 0 0",
                         c, pedestrian_button, turn_sensor, ped_overdue, turn_served, exp_btn, exp_turn);
            end
            reset                 = (c == 57);
            pedestrian_button_raw = (c < 60) || (c >= 80);
            turn_sensor_raw       = (c < 57);
            tick(1);
        end
        pedestrian_button_raw = 1'b0;
        turn_sensor_raw       = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_overdue();
        test_simultaneous();
        test_turn();
        test_turn_served();
        test_reset_mid_request();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
